// File: rtl/product_accumulator.sv
// Sums N_TERMS signed 64-bit products into a guard-bit accumulator per batch.
// The finished sum is held on acc_out/out_valid until the next stage takes it.
module product_accumulator #(
  parameter int N_TERMS   = 8,
  parameter int GUARD     = 8,
  parameter int ACC_WIDTH = 64 + GUARD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 start,
  input  logic                 prod_valid,
  input  logic [63:0]          prod_in,
  output logic                 busy,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8:0]           term_count
);

  // Handshake: the sum transfers on the rising edge where out_valid, out_ready
  // and en are all high; acc_out/out_valid never change while waiting for that.
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;

  localparam logic [8:0] LAST_IDX = 9'(N_TERMS - 1);

  state_t                 state, state_n;
  logic [ACC_WIDTH-1:0]   acc, acc_n, acc_out_n, sum;
  logic [8:0]             cnt_n;
  logic                   out_valid_n;

  assign sum  = acc + {{GUARD{prod_in[63]}}, prod_in};
  assign busy = (state != IDLE);

  always_comb begin
    state_n     = state;
    acc_n       = acc;
    cnt_n       = term_count;
    acc_out_n   = acc_out;
    out_valid_n = out_valid;
    if (en) begin
      case (state)
        IDLE: begin
          if (start) begin
            state_n = ACCUM;
            acc_n   = '0;
            cnt_n   = '0;
          end
        end
        ACCUM: begin
          if (prod_valid) begin
            acc_n = sum;
            cnt_n = term_count + 9'd1;
            if (term_count == LAST_IDX) begin
              state_n     = DONE;
              acc_out_n   = sum;
              out_valid_n = 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_n     = IDLE;
            out_valid_n = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= '0;
      term_count <= '0;
      acc_out    <= '0;
      out_valid  <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      term_count <= cnt_n;
      acc_out    <= acc_out_n;
      out_valid  <= out_valid_n;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator with N_TERMS=4: queued expected sums
// are popped and compared by a monitor each time a new result appears.
module tb_product_accumulator;
  localparam int AW = 72;

  logic          clk = 1'b0;
  logic          reset, en, start, prod_valid, out_ready;
  logic [63:0]   prod_in;
  logic          busy, out_valid;
  logic [AW-1:0] acc_out;
  logic [8:0]    term_count;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] exp_q[$];
  logic [8:0]    cnt_q[$];

  product_accumulator #(.N_TERMS(4), .GUARD(8)) dut (
    .clk(clk), .reset(reset), .en(en), .start(start),
    .prod_valid(prod_valid), .prod_in(prod_in), .busy(busy),
    .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready),
    .term_count(term_count)
  );

  // clock/reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor: one pop per newly presented result
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (out_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %h expected none", acc_out);
      end else begin
        logic [AW-1:0] e;
        logic [8:0]    c;
        e = exp_q.pop_front();
        c = cnt_q.pop_front();
        check("sb_acc_out", acc_out, e);
        check("sb_term_count", AW'(term_count), AW'(c));
      end
    end
    prev_valid = out_valid;
  end

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_batch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [63:0] p);
    prod_valid = 1'b1;
    prod_in    = p;
    tick();
    prod_valid = 1'b0;
    prod_in    = '0;
  endtask

  task automatic push(input logic [AW-1:0] e);
    exp_q.push_back(e);
    cnt_q.push_back(9'd4);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL wait_idle_timeout: busy=%0b expected 0", busy);
    end
  endtask

  task automatic run4(input logic [63:0] p, input logic [AW-1:0] e);
    push(e);
    start_batch();
    for (int i = 0; i < 4; i++) send(p);
    wait_idle();
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; start = 1'b0; prod_valid = 1'b0;
    prod_in = '0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_acc_out", acc_out, '0);
    check("rst_out_valid", AW'(out_valid), '0);
    check("rst_busy", AW'(busy), '0);
    check("rst_term_count", AW'(term_count), '0);
    tick();

    // consecutive positive products
    push(72'h00_0000_0000_6EDA_EA80);
    start_batch();
    @(negedge clk);
    check("busy_after_start", AW'(busy), 1);
    #1;
    for (int i = 0; i < 4; i++) send(64'h1BB6BAA0);
    wait_idle();

    // gaps do not advance term_count
    push(72'h00_0000_0000_132B_3004);
    start_batch();
    send(64'h1BB6BAA0);
    tick(); tick();
    check("gap_term_count", AW'(term_count), 1);
    send(64'hFFFF_FFFF_F774_7564);
    tick(); tick();
    check("gap_term_count2", AW'(term_count), 2);
    send(64'h0); tick(); tick();
    send(64'h0);
    wait_idle();

    run4(64'hFFFF_FFFF_F774_7564, 72'hFF_FFFF_FFFF_DDD1_D590);
    run4(64'h7FFF_FFFF_FFFF_FFFF, 72'h01_FFFF_FFFF_FFFF_FFFC);

    // backpressure in DONE
    out_ready = 1'b0;
    push(72'h1A);
    start_batch();
    send(64'd5); send(64'd6); send(64'd7); send(64'd8);
    for (int i = 0; i < 5; i++) begin
      start      = i[0];
      prod_valid = ~i[0];
      prod_in    = 64'h55;
      tick();
      check("bp_acc_out", acc_out, 72'h1A);
      check("bp_out_valid", AW'(out_valid), 1);
      check("bp_busy", AW'(busy), 1);
    end
    start = 1'b0; prod_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("hs_busy", AW'(busy), 0);
    check("hs_out_valid", AW'(out_valid), 0);
    check("hs_acc_hold", acc_out, 72'h1A);

    // reset mid-batch
    start_batch();
    send(64'd9); send(64'd9);
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid_rst_acc_out", acc_out, '0);
    check("mid_rst_busy", AW'(busy), 0);
    check("mid_rst_term_count", AW'(term_count), 0);
    check("mid_rst_out_valid", AW'(out_valid), 0);
    run4(64'h1, 72'h4);

    // en low mid-batch drops products
    push(72'hA0);
    start_batch();
    send(64'h10);
    en = 1'b0; prod_valid = 1'b1; prod_in = 64'h100;
    tick(); tick(); tick();
    check("en_low_term_count", AW'(term_count), 1);
    en = 1'b1; prod_valid = 1'b0;
    send(64'h20); send(64'h30); send(64'h40);
    wait_idle();

    tick(); tick();
    check("queue_empty", AW'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
